// File: rtl/count_driver_if.sv
// Sequencer-to-driver bundle for the dual-channel En/Slt count driver.
// The sequencer side is master; count_driver takes the slave view.
interface count_driver_if #(
   parameter int CNT_W = 16
);
   logic             Start;
   logic [CNT_W-1:0] Cnt0;
   logic [CNT_W-1:0] Cnt1;
   logic             Hold;
   logic             En;
   logic             Slt;
   logic             Busy;
   logic             DoneP;
   logic [CNT_W-1:0] Done0;
   logic [CNT_W-1:0] Done1;

   modport master (
      output Start, Cnt0, Cnt1, Hold,
      input  En, Slt, Busy, DoneP, Done0, Done1
   );

   modport slave (
      input  Start, Cnt0, Cnt1, Hold,
      output En, Slt, Busy, DoneP, Done0, Done1
   );
endinterface

// File: rtl/count_driver.sv
// Turns a (Cnt0, Cnt1) request into the En/Slt pulse train that advances a downstream
// counter Cnt0 times on channel 0 and Cnt1 times on channel 1 (DIV Slt=1 pulses each).
module count_driver #(
   parameter int CNT_W = 16,
   parameter int DIV   = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   count_driver_if.slave bus
);
   localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [1:0]       S_IDLE  = 2'd0;
   localparam logic [1:0]       S_CH0   = 2'd1;
   localparam logic [1:0]       S_CH1   = 2'd2;
   localparam logic [1:0]       S_DONE  = 2'd3;
   localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1'b1);
   localparam logic [PH_W-1:0]  PH_ZERO = {PH_W{1'b0}};
   localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1'b1);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DIV - 1);

   logic [1:0]       state_r;
   logic [CNT_W-1:0] rem0_r;
   logic [CNT_W-1:0] rem1_r;
   logic [PH_W-1:0]  phase_r;
   logic [CNT_W-1:0] done0_r;
   logic [CNT_W-1:0] done1_r;
   logic             en_r;
   logic             slt_r;
   logic             busy_r;
   logic             donep_r;

   logic             accept_s;
   logic [1:0]       cur_state_s;
   logic [CNT_W-1:0] cur_rem0_s;
   logic [CNT_W-1:0] cur_rem1_s;
   logic [PH_W-1:0]  cur_phase_s;
   logic [CNT_W-1:0] cur_done0_s;
   logic [CNT_W-1:0] cur_done1_s;

   logic [1:0]       state_s;
   logic [CNT_W-1:0] rem0_s;
   logic [CNT_W-1:0] rem1_s;
   logic [PH_W-1:0]  phase_s;
   logic [CNT_W-1:0] done0_s;
   logic [CNT_W-1:0] done1_s;
   logic             en_s;
   logic             slt_s;
   logic             busy_s;
   logic             donep_s;

   // Working context: an accepted Start overlays the fresh request so its first pulse goes out on the same edge.
   always_comb begin
      accept_s    = (state_r == S_IDLE) && !busy_r && bus.Start;
      cur_state_s = state_r;
      cur_rem0_s  = rem0_r;
      cur_rem1_s  = rem1_r;
      cur_phase_s = phase_r;
      cur_done0_s = done0_r;
      cur_done1_s = done1_r;
      if (accept_s) begin
         cur_rem0_s  = bus.Cnt0;
         cur_rem1_s  = bus.Cnt1;
         cur_phase_s = PH_ZERO;
         cur_done0_s = ZERO;
         cur_done1_s = ZERO;
         if (bus.Cnt0 != ZERO) begin
            cur_state_s = S_CH0;
         end else if (bus.Cnt1 != ZERO) begin
            cur_state_s = S_CH1;
         end else begin
            cur_state_s = S_DONE;
         end
      end else begin
         cur_state_s = state_r;
      end
   end

   // Pulse issue and sequencing; Hold freezes everything except En, which drops.
   always_comb begin
      state_s = cur_state_s;
      rem0_s  = cur_rem0_s;
      rem1_s  = cur_rem1_s;
      phase_s = cur_phase_s;
      done0_s = cur_done0_s;
      done1_s = cur_done1_s;
      en_s    = 1'b0;
      slt_s   = slt_r;
      donep_s = 1'b0;
      busy_s  = busy_r;

      // Busy lingers through the DoneP cycle (state already IDLE) so a Start there is ignored.
      if (accept_s) begin
         busy_s = 1'b1;
      end else if (state_r == S_IDLE) begin
         busy_s = 1'b0;
      end else begin
         busy_s = busy_r;
      end

      case (cur_state_s)
         S_IDLE: begin
            state_s = S_IDLE;
         end
         S_CH0: begin
            if (!bus.Hold) begin
               en_s    = 1'b1;
               slt_s   = 1'b0;
               rem0_s  = cur_rem0_s - ONE;
               done0_s = cur_done0_s + ONE;
               if (cur_rem0_s == ONE) begin
                  if (cur_rem1_s != ZERO) begin
                     state_s = S_CH1;
                  end else begin
                     state_s = S_DONE;
                  end
               end else begin
                  state_s = S_CH0;
               end
            end else begin
               state_s = cur_state_s;
            end
         end
         S_CH1: begin
            if (!bus.Hold) begin
               en_s  = 1'b1;
               slt_s = 1'b1;
               if (cur_phase_s == PH_LAST) begin
                  phase_s = PH_ZERO;
                  rem1_s  = cur_rem1_s - ONE;
                  done1_s = cur_done1_s + ONE;
                  if (cur_rem1_s == ONE) begin
                     state_s = S_DONE;
                  end else begin
                     state_s = S_CH1;
                  end
               end else begin
                  phase_s = cur_phase_s + PH_ONE;
                  state_s = S_CH1;
               end
            end else begin
               state_s = cur_state_s;
            end
         end
         S_DONE: begin
            // An empty request spends one cycle in DONE before DoneP, like any other request.
            if (accept_s) begin
               state_s = S_DONE;
            end else begin
               donep_s = 1'b1;
               state_s = S_IDLE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= S_IDLE;
         rem0_r  <= ZERO;
         rem1_r  <= ZERO;
         phase_r <= PH_ZERO;
         done0_r <= ZERO;
         done1_r <= ZERO;
         en_r    <= 1'b0;
         slt_r   <= 1'b0;
         busy_r  <= 1'b0;
         donep_r <= 1'b0;
      end else begin
         state_r <= state_s;
         rem0_r  <= rem0_s;
         rem1_r  <= rem1_s;
         phase_r <= phase_s;
         done0_r <= done0_s;
         done1_r <= done1_s;
         en_r    <= en_s;
         slt_r   <= slt_s;
         busy_r  <= busy_s;
         donep_r <= donep_s;
      end
   end

   assign bus.En    = en_r;
   assign bus.Slt   = slt_r;
   assign bus.Busy  = busy_r;
   assign bus.DoneP = donep_r;
   assign bus.Done0 = done0_r;
   assign bus.Done1 = done1_r;
endmodule

// File: tb/tb_count_driver.sv
// Randomized bench for count_driver: a pulse-count reference model predicts En/Slt/Busy/DoneP/Done0/Done1 every cycle.
module tb_count_driver;
   localparam int CNT_W = 16;
   localparam int DIV   = 4;

   logic Clk;
   logic Reset;

   count_driver_if #(.CNT_W(CNT_W)) bus ();

   count_driver #(.CNT_W(CNT_W), .DIV(DIV)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int chk_cnt = 0;
   int err_cnt = 0;

   // Reference model: a request is just c0 ch0 pulses followed by DIV*c1 ch1 pulses.
   int m_stage;   // 0 idle, 1 issuing, 2 DoneP due next edge, 3 Busy drops next edge
   int m_c0, m_c1, m_total, m_issued;
   int m_done0, m_done1;
   int m_en, m_slt, m_busy, m_donep;
   int en_cnt, donep_cnt;

   task automatic check_val(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_stage = 0; m_c0 = 0; m_c1 = 0; m_total = 0; m_issued = 0;
      m_done0 = 0; m_done1 = 0; m_en = 0; m_slt = 0; m_busy = 0; m_donep = 0;
   endtask

   task automatic model_edge(input int st, input int a, input int b, input int h);
      m_en    = 0;
      m_donep = 0;
      if (m_stage == 2) begin
         m_donep = 1;
         m_stage = 3;
      end else if (m_stage == 3) begin
         m_busy  = 0;
         m_stage = 0;
      end else begin
         if (m_stage == 0 && st != 0) begin
            m_c0 = a; m_c1 = b; m_total = a + DIV * b; m_issued = 0;
            m_done0 = 0; m_done1 = 0; m_busy = 1; m_stage = 1;
         end
         if (m_stage == 1) begin
            if (h == 0 && m_issued < m_total) begin
               m_en  = 1;
               m_slt = (m_issued < m_c0) ? 0 : 1;
               m_issued++;
               m_done0 = (m_issued < m_c0) ? m_issued : m_c0;
               m_done1 = (m_issued > m_c0) ? (m_issued - m_c0) / DIV : 0;
            end
            if (m_issued == m_total) m_stage = 2;
         end
      end
   endtask

   task automatic check_outputs();
      check_val("en",    int'(bus.En),    m_en);
      check_val("slt",   int'(bus.Slt),   m_slt);
      check_val("busy",  int'(bus.Busy),  m_busy);
      check_val("donep", int'(bus.DoneP), m_donep);
      check_val("done0", int'(bus.Done0), m_done0);
      check_val("done1", int'(bus.Done1), m_done1);
   endtask

   // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
   task automatic tick(input logic st, input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b, input logic h);
      bus.Start = st;
      bus.Cnt0  = a;
      bus.Cnt1  = b;
      bus.Hold  = h;
      @(posedge Clk);
      model_edge(int'(st), int'(a), int'(b), int'(h));
      @(negedge Clk);
      check_outputs();
      if (bus.En)    en_cnt++;
      if (bus.DoneP) donep_cnt++;
   endtask

   task automatic do_reset();
      bus.Start = 1'b0;
      bus.Hold  = 1'b0;
      #1 Reset = 1'b0;
      #1;
      check_val("rst_en",    int'(bus.En),    0);
      check_val("rst_busy",  int'(bus.Busy),  0);
      check_val("rst_done0", int'(bus.Done0), 0);
      check_val("rst_done1", int'(bus.Done1), 0);
      check_val("rst_donep", int'(bus.DoneP), 0);
      model_reset();
      @(negedge Clk);
      Reset = 1'b1;
   endtask

   // hmode: 0 no hold, 1 random hold, 2 hold three cycles after the second pulse.
   task automatic run_req(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                          input int hmode, input logic spam, input int rst_at);
      int   guard;
      int   limit;
      int   held;
      logic h;
      logic st;
      en_cnt    = 0;
      donep_cnt = 0;
      held      = 0;
      h         = (hmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick(1'b1, c0, c1, h);
      guard = 0;
      limit = 4 * (int'(c0) + DIV * int'(c1)) + 64;
      while (m_stage != 0 && guard < limit) begin
         if (rst_at > 0 && m_issued == rst_at) begin
            do_reset();
            return;
         end
         if (hmode == 1) begin
            h = ($urandom_range(0, 3) == 0);
         end else if (hmode == 2 && en_cnt >= 2 && held < 3) begin
            h = 1'b1;
            held++;
         end else begin
            h = 1'b0;
         end
         st = spam ? 1'(($urandom_range(0, 1))) : 1'b0;
         tick(st, CNT_W'($urandom()), CNT_W'($urandom()), h);
         guard++;
      end
      check_val("finish",    m_stage,   0);
      check_val("pulses",    en_cnt,    int'(c0) + DIV * int'(c1));
      check_val("donep_cnt", donep_cnt, 1);
   endtask

   initial begin
      Reset     = 1'b0;
      bus.Start = 1'b0;
      bus.Cnt0  = {CNT_W{1'b0}};
      bus.Cnt1  = {CNT_W{1'b0}};
      bus.Hold  = 1'b0;
      model_reset();
      en_cnt    = 0;
      donep_cnt = 0;
      repeat (2) @(negedge Clk);
      check_outputs();
      Reset = 1'b1;
      @(negedge Clk);
      check_outputs();

      run_req(16'd3, 16'd0, 0, 1'b0, 0);
      run_req(16'd2, 16'd2, 0, 1'b0, 0);
      run_req(16'd4, 16'd1, 2, 1'b0, 0);
      run_req(16'd0, 16'd0, 0, 1'b0, 0);
      run_req(16'd5, 16'd0, 0, 1'b1, 0);
      run_req(16'd0, 16'd1, 0, 1'b0, 3);
      run_req(16'd0, 16'd1, 0, 1'b0, 0);

      // Idle cycles: Done0/Done1 hold, Hold is irrelevant.
      repeat (3) tick(1'b0, 16'd7, 16'd7, 1'($urandom_range(0, 1)));

      for (int i = 0; i < 30; i++) begin
         run_req(CNT_W'($urandom_range(0, 15)), CNT_W'($urandom_range(0, 10)),
                 $urandom_range(0, 1), 1'($urandom_range(0, 1)), 0);
         repeat ($urandom_range(0, 2)) tick(1'b0, 16'd0, 16'd0, 1'($urandom_range(0, 1)));
      end

      run_req(16'hFFFF, 16'd0, 0, 1'b0, 0);
      tick(1'b0, 16'd0, 16'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/count_driver.md
Name: count_driver

Overview:
- Stimulus side of the dual-channel En/Slt counting interface: turns a request for N0 channel-0 increments and N1 channel-1 increments into the exact En/Slt pulse train that produces them in a downstream counter.
- In the downstream counter, channel 0 advances once per Slt=0 pulse and channel 1 advances once per DIV Slt=1 pulses.
- Sits between a test/control sequencer (Start/Done handshake) and the counter's En/Slt inputs.

Parameters:
CNT_W, 16, width of requested counts Cnt0/Cnt1 and of the Done0/Done1 progress counters
DIV, 4, Slt=1 pulses per channel-1 increment; legal range 2..16

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset
Start  input  1  request strobe; sampled only in IDLE
Cnt0  input  CNT_W  channel-0 increments requested; latched on accepted Start
Cnt1  input  CNT_W  channel-1 increments requested; latched on accepted Start
Hold  input  1  stall; while 1, no pulse is issued and no progress is made
En  output  1  registered enable to the counter
Slt  output  1  registered channel select to the counter (0 = ch0, 1 = ch1)
Busy  output  1  high from the cycle after an accepted Start until the cycle after DONE
DoneP  output  1  one-cycle completion pulse
Done0  output  CNT_W  channel-0 increments completed in the current/last request
Done1  output  CNT_W  channel-1 increments completed (counts full DIV-pulse groups only)

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; En, Slt, Busy, DoneP = 0; Done0, Done1 = 0; internal remaining counts and phase = 0.
- States: IDLE, CH0, CH1, DONE.
- IDLE, Start=1 at edge k:
  - latch Cnt0/Cnt1; clear Done0/Done1; Busy=1 from cycle k+1.
  - next state: CH0 if Cnt0≠0; else CH1 if Cnt1≠0; else DONE.
- CH0, each edge with Hold=0:
  - En=1, Slt=0 in the following cycle; rem0 decrements; Done0 increments.
  - After the Cnt0-th pulse: next state CH1 if Cnt1≠0, else DONE.
- CH1:
  - Total pulses issued = DIV*Cnt1, each En=1, Slt=1.
  - Phase counter runs 0..DIV-1. When phase wraps DIV-1→0: Done1 increments and rem1 decrements.
  - After the last group: next state DONE.
- Hold=1 at an edge: next cycle En=0; Slt keeps its previous value; state, counters and phase frozen. Hold has no effect in IDLE/DONE.
- Pulse timing:
  - En deasserts the cycle after the final pulse (En=0 in DONE).
  - Back-to-back pulses with no idle gap when Hold=0.
  - Switch CH0→CH1 is seamless: the last Slt=0 pulse is immediately followed by the first Slt=1 pulse.
- DONE: DoneP=1 for exactly one cycle, En=0; next state IDLE; Busy drops the cycle after DoneP.
- Start while Busy: ignored, no latch.
- Start in the same cycle DoneP is high: ignored. Start is accepted only from IDLE.
- Cnt0=Cnt1=0: Start → DONE → DoneP one cycle later; no En pulse at all.
- Max counts (all ones): no overflow. rem counters are CNT_W wide; the phase counter is clog2(DIV) wide.
- Reset mid-operation: En drops immediately (async); Done0/Done1 cleared; pending pulses discarded.
- Done0/Done1 hold their final values in IDLE until the next accepted Start.

Test Plan:
- Reset, then Start with Cnt0=3, Cnt1=0, Hold=0 → En=1, Slt=0 for 3 consecutive cycles starting the cycle after Start; DoneP the next cycle; Done0=3, Done1=0; Busy high for 4 cycles.
- Start with Cnt0=2, Cnt1=2, DIV=4 → 2 pulses with Slt=0, then 8 contiguous pulses with Slt=1; Done1 steps 0→1 after the 4th Slt=1 pulse and 1→2 after the 8th; DoneP the cycle after; an attached counter reads Output0=2, Output1=2.
- Cnt0=4, Cnt1=1, Hold=1 for 3 cycles after the 2nd pulse → En=0 for those 3 cycles, then 2 remaining Slt=0 pulses plus 4 Slt=1 pulses; total En-high cycles = 8.
- Cnt0=0, Cnt1=0 → no En pulse; DoneP 1 cycle after Start. Second Start asserted while Busy=1 in a Cnt0=5 run → ignored; exactly 5 pulses issued.
- Reset pulled low during the 3rd Slt=1 pulse of Cnt1=1 → En, Busy, Done0, Done1 = 0 immediately; after release, a new Start with Cnt1=1 yields exactly 4 Slt=1 pulses and Done1=1.
- Cnt0=16'hFFFF → 65535 Slt=0 pulses; Done0=16'hFFFF; no wrap; DoneP once.
